mseq_load_txn_sched: RTL
========================

// Module: mseq_load_txn_sched
// PURPOSE
// - Request-side scheduler for the matrix sequential-load path.
// - Takes one strided matrix-load request (base, stride, rows, row bytes) and splits every row into AXI INCR bursts.
// - Bursts never cross a 4 KiB page and are at most 256 beats long.
// - Issues one AR per burst. Feeds the R-side committer a per-beat txn_ctrl stream (addr/isHead/isFinalTxn/rmnBeat/lbN).
// - Issues one meta_glb record (vstart/sew) per request.
// PARAMETERS
// - AxiDataWidth  128  R/AR bus width in bits; BusBytes=AxiDataWidth/8, busNibbles=AxiDataWidth/4.
// - AxiAddrWidth  64   address width.
// - TxnQDepth     4    outstanding-txn FIFO depth (power of 2, >=2).
// - mreq_t / axi_ar_t / txn_ctrl_t / meta_glb_t   logic   struct type parameters.
// PORTS
// - clk_i             in   1     clock.
// - rst_ni            in   1     asynchronous active-low reset.
// - req_valid_i       in   1     matrix-load request valid.
// - req_ready_o       out  1     high only in S_IDLE.
// - req_i             in   mreq_t  {base, stride, nrRows[15:0], rowBytes[15:0], vstart, sew}.
// - meta_glb_valid_o  out  1     meta record valid.
// - meta_glb_ready_i  in   1     meta record ready.
// - meta_glb_o        out  meta_glb_t  {vstart, sew} of the latched request.
// - ar_valid_o        out  1     AR valid.
// - ar_ready_i        in   1     AR ready.
// - ar_o              out  axi_ar_t  {addr, len, size=log2(BusBytes), burst=INCR}.
// - txn_ctrl_valid_o  out  1     head-of-FIFO txn valid.
// - txn_ctrl_ready_i  in   1     one R beat consumed.
// - txn_ctrl_o        out  txn_ctrl_t  head-of-FIFO txn entry.
// - busy_o            out  1     state != S_IDLE.
// - done_o            out  1     1-cycle pulse when the request fully completes.
// BEHAVIOUR
// - Reset: state=S_IDLE, FIFO empty, all counters 0. All valid outputs, busy_o and done_o are 0; req_ready_o=1.
// - FSM:
//   - S_IDLE -(req fire, nrRows!=0 && rowBytes!=0)-> S_META.
//   - S_IDLE -(req fire, zero-size request)-> S_DONE.
//   - S_META: meta_glb_valid_o=1 -(meta fire)-> S_ISSUE.
//   - S_ISSUE -(AR fire of last burst of last row)-> S_DRAIN.
//   - S_DRAIN -(FIFO empty)-> S_DONE.
//   - S_DONE: done_o=1 for one cycle -> S_IDLE.
// - Request fields are latched on fire. Row cursor cur_addr and rem (row bytes left) load from base/rowBytes.
// - Burst split, with off=cur_addr%BusBytes:
//   - chunk = min(rem, 4096-cur_addr[11:0], 256*BusBytes-off).
//   - len = ((off+chunk+BusBytes-1)/BusBytes)-1.
//   - e = (cur_addr+chunk)%BusBytes; lbN = (e==0) ? busNibbles : 2*e. lbN is $clog2(busNibbles)+1 bits.
//   - All arithmetic is unsigned; intermediates carry 1 guard bit; no truncation of chunk.
// - ar_valid_o = (state==S_ISSUE) && !fifo_full.
// - AR fire pushes {addr=cur_addr, isHead=1, isFinalTxn=(last row && chunk==rem), rmnBeat=len, lbN} into the FIFO in the same cycle.
// - After each AR fire: cur_addr+=chunk, rem-=chunk.
// - When rem hits 0 at end of row: row base+=stride, cur_addr=row base, rem=rowBytes, rows_left--.
// - Txn FIFO pop rules:
//   - txn_ctrl_valid_o = !fifo_empty; txn_ctrl_o = head entry.
//   - On txn_ctrl_ready_i && valid: if head.rmnBeat==0, pop; else rmnBeat--, isHead=0 in place.
// - Simultaneous push and pop on a full FIFO is not allowed: push requires !fifo_full evaluated before the pop.
// - Push into an empty FIFO is visible on txn_ctrl_o next cycle (no bypass).
// - AR and meta are independent: AR may fire before the R side has consumed meta.
// - txn_ctrl_ready_i while FIFO empty is ignored.
// - Request arrival while busy: req_ready_o=0, request held off.
// - Reset mid-operation: FIFO flushed, no done_o pulse, return to S_IDLE.
// STRUCTURE
// - vlsu_pkg gains mreq_t, the txn_ctrl_t field widths, and localparam PageBytes=4096, MaxBurstBeats=256.
// - One sub-module: mseq_txn_fifo. Circular FIFO using CircularQueuePtrTemplate ptrs, with head-entry in-place beat decrement.
// - Burst-split math is a single combinational function in this file.
// TESTING (AxiDataWidth=128: BusBytes=16, busNibbles=32)
// - base=0x1000, rows=1, rowBytes=64 -> AR{0x1000,len=3}; txn{isHead,rmnBeat=3,lbN=32,isFinalTxn}; 4 ready beats -> FIFO empty, done_o pulse.
// - base=0x1004, rowBytes=20 -> AR{0x1004,len=1}; lbN=16; isHead clears after first ready, rmnBeat 1->0, pop on second.
// - base=0x1FF0, rowBytes=32 -> two ARs {0x1FF0,len=0,lbN=32} and {0x2000,len=0,lbN=32}; only the second has isFinalTxn=1.
// - base=0, stride=0x100, rows=3, rowBytes=16 -> ARs at 0x0,0x100,0x200, len=0 each; meta_glb fired once, before the first AR.
// - TxnQDepth=2, txn_ctrl_ready_i=0 -> ar_valid_o drops after 2 ARs; it resumes one cycle after the first pop.
// - Assert rst_ni mid S_ISSUE -> all valids 0 next edge, req_ready_o=1, no done_o; new request then runs normally.

Source files
------------

// File: rtl/mseq_load_txn_sched_pkg.sv
// Shared types and constants for the matrix sequential-load request scheduler.
// Struct field widths assume the default 128-bit data / 64-bit address bus.
package mseq_load_txn_sched_pkg;

    localparam int unsigned DefAxiDataWidth = 128;
    localparam int unsigned DefAxiAddrWidth = 64;
    localparam int unsigned DefBusNibbles   = DefAxiDataWidth / 4;
    localparam int unsigned LbnWidth        = $clog2(DefBusNibbles) + 1;
    localparam int unsigned PageBytes       = 4096;
    localparam int unsigned MaxBurstBeats   = 256;
    localparam logic [1:0]  BurstIncr       = 2'b01;

    typedef struct packed {
        logic [DefAxiAddrWidth-1:0] base;
        logic [DefAxiAddrWidth-1:0] stride;
        logic [15:0]                nr_rows;
        logic [15:0]                row_bytes;
        logic [15:0]                vstart;
        logic [2:0]                 sew;
    } mreq_t;

    typedef struct packed {
        logic [15:0] vstart;
        logic [2:0]  sew;
    } meta_glb_t;

    typedef struct packed {
        logic [DefAxiAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi_ar_t;

    typedef struct packed {
        logic [DefAxiAddrWidth-1:0] addr;
        logic                       is_head;
        logic                       is_final_txn;
        logic [7:0]                 rmn_beat;
        logic [LbnWidth-1:0]        lbn;
    } txn_ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_META,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/mseq_load_txn_sched_txn_fifo.sv
// Outstanding-burst queue: circular buffer with wrap-flag pointers. The head
// entry counts its own beats down in place and is popped on its last beat.
module mseq_txn_fifo
    import mseq_load_txn_sched_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = txn_ctrl_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    input  logic   beat,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned IdxW = $clog2(Depth);

    typedef struct packed {
        logic            flag;
        logic [IdxW-1:0] idx;
    } ptr_t;

    ptr_t   wr_ptr, rd_ptr;
    entry_t mem [Depth];
    logic   take, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        n = p;
        if (p.idx == IdxW'(Depth - 1)) begin
            n.idx  = '0;
            n.flag = ~p.flag;
        end else begin
            n.idx = p.idx + 1'b1;
        end
        return n;
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr.idx == rd_ptr.idx) && (wr_ptr.flag != rd_ptr.flag);
    assign head  = mem[rd_ptr.idx];
    assign take  = beat && !empty;
    assign pop   = take && (head.rmn_beat == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Push never targets the head slot while it is live: that needs wr==rd, i.e. full.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr.idx] <= din;
        if (take && !pop) begin
            mem[rd_ptr.idx].rmn_beat <= head.rmn_beat - 1'b1;
            mem[rd_ptr.idx].is_head  <= 1'b0;
        end
    end

endmodule

// File: rtl/mseq_load_txn_sched.sv
// Request-side scheduler for strided matrix loads: splits each row into
// page-safe INCR bursts, issues one AR per burst and feeds the R-side committer.
module mseq_load_txn_sched
    import mseq_load_txn_sched_pkg::*;
#(
    parameter int unsigned AxiDataWidth = DefAxiDataWidth,
    parameter int unsigned AxiAddrWidth = DefAxiAddrWidth,
    parameter int unsigned TxnQDepth    = 4,
    parameter type         req_t        = mreq_t,
    parameter type         ar_t         = axi_ar_t,
    parameter type         txn_t        = txn_ctrl_t,
    parameter type         meta_t       = meta_glb_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  req_valid_i,
    output logic  req_ready_o,
    input  req_t  req_i,
    output logic  meta_glb_valid_o,
    input  logic  meta_glb_ready_i,
    output meta_t meta_glb_o,
    output logic  ar_valid_o,
    input  logic  ar_ready_i,
    output ar_t   ar_o,
    output logic  txn_ctrl_valid_o,
    input  logic  txn_ctrl_ready_i,
    output txn_t  txn_ctrl_o,
    output logic  busy_o,
    output logic  done_o
);

    localparam int unsigned BusBytes   = AxiDataWidth / 8;
    localparam int unsigned BusNibbles = AxiDataWidth / 4;
    localparam int unsigned OffW       = $clog2(BusBytes);
    localparam int unsigned LbnW       = $clog2(BusNibbles) + 1;
    localparam int unsigned CW         = 17;

    typedef struct packed {
        logic [CW-1:0]   chunk;
        logic [7:0]      len;
        logic [LbnW-1:0] lbn;
    } split_t;

    // Bytes the next burst can cover from addr: bounded by the row remainder,
    // the 4 KiB page edge and the 256-beat limit measured from the aligned start.
    function automatic split_t split_burst(input logic [11:0] addr_lo, input logic [CW-1:0] rem_b);
        logic [CW-1:0]   off, page_left, beat_left, chunk, span;
        logic [OffW-1:0] e;
        split_t          s;
        off       = CW'(addr_lo[OffW-1:0]);
        page_left = CW'(PageBytes) - CW'(addr_lo);
        beat_left = CW'(MaxBurstBeats * BusBytes) - off;
        chunk     = rem_b;
        if (page_left < chunk) chunk = page_left;
        if (beat_left < chunk) chunk = beat_left;
        span      = off + chunk + CW'(BusBytes - 1);
        e         = addr_lo[OffW-1:0] + chunk[OffW-1:0];
        s.chunk   = chunk;
        s.len     = 8'((span >> OffW) - 1'b1);
        s.lbn     = (e == '0) ? LbnW'(BusNibbles) : LbnW'({e, 1'b0});
        return s;
    endfunction

    state_e                  state, state_n;
    logic [AxiAddrWidth-1:0] cur_addr, row_base, stride;
    logic [15:0]             row_bytes, rem, rows_left;
    meta_t                   meta_q;
    split_t                  burst;
    txn_t                    push_entry;
    logic                    fifo_full, fifo_empty;
    logic                    req_fire, ar_fire, row_done, is_final;

    assign burst    = split_burst(cur_addr[11:0], {1'b0, rem});
    assign row_done = (burst.chunk == {1'b0, rem});
    assign is_final = row_done && (rows_left == 16'd1);
    assign req_fire = req_valid_i && req_ready_o;
    assign ar_fire  = ar_valid_o && ar_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n          = state;
        req_ready_o      = 1'b0;
        meta_glb_valid_o = 1'b0;
        ar_valid_o       = 1'b0;
        busy_o           = 1'b1;
        done_o           = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i)
                    state_n = (req_i.nr_rows != '0 && req_i.row_bytes != '0) ? S_META : S_DONE;
            end
            S_META: begin
                meta_glb_valid_o = 1'b1;
                if (meta_glb_ready_i) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                ar_valid_o = !fifo_full;
                if (ar_valid_o && ar_ready_i && is_final) state_n = S_DRAIN;
            end
            S_DRAIN: if (fifo_empty) state_n = S_DONE;
            S_DONE: begin
                done_o  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr  <= '0;
            row_base  <= '0;
            stride    <= '0;
            row_bytes <= '0;
            rem       <= '0;
            rows_left <= '0;
            meta_q    <= '0;
        end else if (req_fire) begin
            cur_addr      <= req_i.base;
            row_base      <= req_i.base;
            stride        <= req_i.stride;
            row_bytes     <= req_i.row_bytes;
            rem           <= req_i.row_bytes;
            rows_left     <= req_i.nr_rows;
            meta_q.vstart <= req_i.vstart;
            meta_q.sew    <= req_i.sew;
        end else if (ar_fire) begin
            if (row_done) begin
                cur_addr  <= row_base + stride;
                row_base  <= row_base + stride;
                rem       <= row_bytes;
                rows_left <= rows_left - 1'b1;
            end else begin
                cur_addr <= cur_addr + AxiAddrWidth'(burst.chunk);
                rem      <= rem - burst.chunk[15:0];
            end
        end
    end

    always_comb begin
        ar_o       = '0;
        ar_o.addr  = cur_addr;
        ar_o.len   = burst.len;
        ar_o.size  = 3'(OffW);
        ar_o.burst = BurstIncr;
    end

    always_comb begin
        push_entry              = '0;
        push_entry.addr         = cur_addr;
        push_entry.is_head      = 1'b1;
        push_entry.is_final_txn = is_final;
        push_entry.rmn_beat     = burst.len;
        push_entry.lbn          = burst.lbn;
    end

    assign meta_glb_o       = meta_q;
    assign txn_ctrl_valid_o = !fifo_empty;

    mseq_txn_fifo #(
        .Depth   (TxnQDepth),
        .entry_t (txn_t)
    ) u_txn_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (ar_fire),
        .din   (push_entry),
        .beat  (txn_ctrl_ready_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (txn_ctrl_o)
    );

endmodule
